// File: rtl/beep_scheduler.sv
// beep_scheduler
//   Shares one beeper between NREQ requesters and plays multi-beep patterns.
//   Fixed priority (index 0 highest), non-preemptive. Trigger spacing is
//   enforced here because the beeper has no busy output and ignores BP_IN
//   while it runs its cycle.
//
// Ports
//   clk        system clock, rising edge
//   resetn     synchronous active-low reset; enters a PERIOD-long holdoff
//   req        level request per requester
//   req_cnt    beep count per requester, field i at [i*CW +: CW]
//   abort      cancel the running sequence
//   ack        one-hot, one-cycle acceptance pulse
//   busy       high in every state except IDLE
//   active_id  index of the last granted requester
//   done       one-cycle pulse on normal completion
//   bp_trig    one-cycle trigger to the beeper
module beep_scheduler #(
    parameter int NREQ   = 4,
    parameter int CW     = 4,
    parameter int PERIOD = 184321,
    parameter int GAP    = 1843200,
    parameter int TW     = 24,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] req_cnt,
    input  logic               abort,
    output logic [NREQ-1:0]    ack,
    output logic               busy,
    output logic [IDW-1:0]     active_id,
    output logic               done,
    output logic               bp_trig
);

    localparam logic [TW-1:0] PERIOD_M1 = TW'(PERIOD - 1);
    localparam logic [TW-1:0] GAP_M1    = (GAP > 0) ? TW'(GAP - 1) : '0;
    localparam bit            HAS_GAP   = (GAP > 0);

    typedef enum logic [2:0] {
        HOLD,
        IDLE,
        WAIT_ON,
        WAIT_GAP,
        DONE
    } state_e;

    state_e            state, state_nx;
    logic [TW-1:0]     timer, timer_nx;
    logic [CW-1:0]     rem, rem_nx;
    logic              aborted, aborted_nx;
    logic [NREQ-1:0]   ack_nx;
    logic [IDW-1:0]    id_nx;
    logic              done_nx;
    logic              trig_nx;
    logic [IDW-1:0]    grant_idx;
    logic [CW-1:0]     grant_cnt;

    // Lowest set index wins.
    function automatic logic [IDW-1:0] first_set(input logic [NREQ-1:0] v);
        first_set = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) first_set = IDW'(i);
        end
    endfunction

    assign grant_idx = first_set(req);
    assign grant_cnt = req_cnt[grant_idx*CW +: CW];

    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        rem_nx     = rem;
        aborted_nx = aborted;
        ack_nx     = '0;
        id_nx      = active_id;
        done_nx    = 1'b0;
        trig_nx    = 1'b0;

        case (state)
            HOLD: begin
                if (timer == '0) state_nx = IDLE;
                else             timer_nx = timer - 1'b1;
            end

            IDLE: begin
                if (|req) begin
                    ack_nx[grant_idx] = 1'b1;
                    id_nx             = grant_idx;
                    rem_nx            = grant_cnt;
                    aborted_nx        = 1'b0;
                    if (grant_cnt != '0) begin
                        trig_nx  = 1'b1;
                        timer_nx = PERIOD_M1;
                        state_nx = WAIT_ON;
                    end else begin
                        state_nx = DONE;
                    end
                end
            end

            WAIT_ON: begin
                // An abort here must let the running beep period expire so
                // the next grant's trigger is not swallowed by the beeper.
                if (abort) begin
                    aborted_nx = 1'b1;
                    rem_nx     = CW'(1);
                end
                if (timer == '0) begin
                    if (abort || aborted) begin
                        state_nx = IDLE;
                    end else if (rem > CW'(1)) begin
                        rem_nx = rem - 1'b1;
                        if (HAS_GAP) begin
                            timer_nx = GAP_M1;
                            state_nx = WAIT_GAP;
                        end else begin
                            trig_nx  = 1'b1;
                            timer_nx = PERIOD_M1;
                        end
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = DONE;
                    end
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end

            WAIT_GAP: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (timer == '0) begin
                    trig_nx  = 1'b1;
                    timer_nx = PERIOD_M1;
                    state_nx = WAIT_ON;
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end

            DONE: begin
                // Entered from WAIT_ON with done already set; a zero-count
                // grant arrives with done clear and emits it one cycle later.
                if (abort || done) state_nx = IDLE;
                else               done_nx  = 1'b1;
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= HOLD;
            timer     <= PERIOD_M1;
            aborted   <= 1'b0;
            ack       <= '0;
            busy      <= 1'b1;
            active_id <= '0;
            done      <= 1'b0;
            bp_trig   <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            aborted   <= aborted_nx;
            ack       <= ack_nx;
            busy      <= (state_nx != IDLE);
            active_id <= id_nx;
            done      <= done_nx;
            bp_trig   <= trig_nx;
        end
    end

    // Beep count is only meaningful after a grant, so it carries no reset.
    always_ff @(posedge clk) begin
        rem <= rem_nx;
    end

endmodule
